// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out word assembler with a held output word and sticky overrun.
// Optional even-parity bit after each word when DESER_PARITY_EN is defined.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  input  logic             s_bit,
  output logic             s_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
`ifdef DESER_PARITY_EN
  ,
  output logic             parity_err
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
`ifdef DESER_PARITY_EN
    PARITY,
`endif
    HOLD
  } state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_nx, dout_q, dout_d;
  logic ov_q, ov_d, accept, last;
`ifdef DESER_PARITY_EN
  logic perr_q, perr_d;
  assign parity_err = perr_q;
`endif
  assign s_ready   = (state_q != HOLD) || out_ready;
  assign accept    = s_valid && s_ready;
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign sh_nx     = (MSB_FIRST != 0) ? {sh_q[WIDTH-2:0], s_bit} : {s_bit, sh_q[WIDTH-1:1]};
  assign out_valid = state_q == HOLD;
  assign d_out     = dout_q;
  assign overrun   = ov_q;
  // Next-state: shift on every accepted data bit, complete the word into d_out, drop bits while held
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = accept ? sh_nx : sh_q;
    dout_d  = dout_q;
    ov_d    = ov_q || (s_valid && !s_ready);
`ifdef DESER_PARITY_EN
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
        state_d = COLLECT;
        cnt_d   = CW'(1);
      end
      COLLECT: if (accept) begin
        if (last) begin
          cnt_d   = '0;
`ifdef DESER_PARITY_EN
          state_d = PARITY;
`else
          state_d = HOLD;
          dout_d  = sh_nx;
`endif
        end else cnt_d = cnt_q + CW'(1);
      end
`ifdef DESER_PARITY_EN
      PARITY: if (accept) begin
        sh_d    = sh_q;
        state_d = HOLD;
        dout_d  = sh_q;
        perr_d  = ^{sh_q, s_bit};
      end
`endif
      HOLD: if (out_ready) begin
        state_d = accept ? COLLECT : IDLE;
        cnt_d   = accept ? CW'(1) : '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and data registers, cleared immediately by the active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      ov_q    <= 1'b0;
`ifdef DESER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      ov_q    <= ov_d;
`ifdef DESER_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of an MSB-first and an LSB-first instance driven in parallel.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic reset, s_valid, s_bit, out_ready;
  logic s_ready, out_valid, overrun, s_ready2, out_valid2, overrun2;
  logic [3:0] d_out, d_out2;
`ifdef DESER_PARITY_EN
  logic parity_err, parity_err2;
`endif
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready),
    .d_out(d_out), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
`ifdef DESER_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_bit(s_bit), .s_ready(s_ready2),
    .d_out(d_out2), .out_valid(out_valid2), .out_ready(out_ready), .overrun(overrun2)
`ifdef DESER_PARITY_EN
    , .parity_err(parity_err2)
`endif
  );

  task automatic send_bit(input logic b);
    s_valid = 1'b1;
    s_bit   = b;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_parity(input logic [3:0] w);
`ifdef DESER_PARITY_EN
    send_bit(^w);
`else
    if (w === 4'bxxxx) $display("unreachable");
`endif
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_bit = 1'b0; out_ready = 1'b1;
    #2;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready got %b want 1", s_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (d_out !== 4'b0000) begin n_bad++; $display("FAIL rst_d_out got %b want 0000", d_out); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", overrun); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bit_order();
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL order_early_valid got %b want 0", out_valid); end
    send_bit(1'b1);
    send_parity(4'b1011);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL order_valid got %b want 1", out_valid); end
    n_cmp++; if (d_out !== 4'b1011) begin n_bad++; $display("FAIL order_msb_word got %b want 1011", d_out); end
    n_cmp++; if (d_out2 !== 4'b1101) begin n_bad++; $display("FAIL order_lsb_word got %b want 1101", d_out2); end
    idle_cycle();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL order_valid_drop got %b want 0", out_valid); end
    n_cmp++; if (d_out !== 4'b1011) begin n_bad++; $display("FAIL order_retain got %b want 1011", d_out); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL order_ready got %b want 1", s_ready); end
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_parity(4'b1011);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL ovr_ready_low got %b want 0", s_ready); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_pre got %b want 0", overrun); end
    s_valid = 1'b1; s_bit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (d_out !== 4'b1011) begin n_bad++; $display("FAIL ovr_hold_word got %b want 1011", d_out); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_hold_valid got %b want 1", out_valid); end
      n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got %b want 1", overrun); end
    end
    s_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL ovr_ready_follow got %b want 1", s_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_consumed got %b want 0", out_valid); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    reset = 1'b0;
    #1;
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_reset_clear got %b want 0", overrun); end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    s_valid = 1'b0; s_bit = 1'bx;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_x_ignored got valid=%b ready=%b want 0/1", out_valid, s_ready); end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    send_parity(4'b1100);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_w1_valid got %b want 1", out_valid); end
    n_cmp++; if (d_out !== 4'b1100) begin n_bad++; $display("FAIL b2b_w1 got %b want 1100", d_out); end
    n_cmp++; if (d_out2 !== 4'b0011) begin n_bad++; $display("FAIL b2b_w1_lsb got %b want 0011", d_out2); end
    send_bit(1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_consume got %b want 0", out_valid); end
    n_cmp++; if (d_out !== 4'b1100) begin n_bad++; $display("FAIL b2b_retain got %b want 1100", d_out); end
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_parity(4'b0011);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_w2_valid got %b want 1", out_valid); end
    n_cmp++; if (d_out !== 4'b0011) begin n_bad++; $display("FAIL b2b_w2 got %b want 0011", d_out); end
    n_cmp++; if (d_out2 !== 4'b1100) begin n_bad++; $display("FAIL b2b_w2_lsb got %b want 1100", d_out2); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    reset = 1'b0;
    #1;
    n_cmp++; if (d_out !== 4'b0000) begin n_bad++; $display("FAIL mid_async_dout got %b want 0000", d_out); end
    #1;
    reset = 1'b1;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_early_valid got %b want 0", out_valid); end
    send_bit(1'b1);
    send_parity(4'b0001);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid got %b want 1", out_valid); end
    n_cmp++; if (d_out !== 4'b0001) begin n_bad++; $display("FAIL mid_word got %b want 0001", d_out); end
    n_cmp++; if (d_out2 !== 4'b1000) begin n_bad++; $display("FAIL mid_word_lsb got %b want 1000", d_out2); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL mid_overrun got %b want 0", overrun); end
    idle_cycle();
  endtask

`ifdef DESER_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    n_cmp++; if (out_valid !== 1'b0 || s_ready !== 1'b1) begin n_bad++; $display("FAIL par_wait got valid=%b ready=%b want 0/1", out_valid, s_ready); end
    send_bit(1'b0);
    n_cmp++; if (d_out !== 4'b1011) begin n_bad++; $display("FAIL par_word got %b want 1011", d_out); end
    n_cmp++; if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_bad got %b want 1", parity_err); end
    idle_cycle();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    n_cmp++; if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_good got %b want 0", parity_err); end
    idle_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_bit_order();
    test_overrun();
    test_back_to_back();
    test_reset_mid_word();
`ifdef DESER_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sipo_deserializer.md
SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning data word width in bits (legal 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = first serial bit lands in d_out[WIDTH-1]; 0 = first serial bit lands in d_out[0].
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port s_valid  input  1  serial bit present on s_bit.
REQ-006 SHALL have port s_bit  input  1  serial data bit.
REQ-007 SHALL have port s_ready  output  1  block can accept a serial bit this cycle.
REQ-008 SHALL have port d_out  output  WIDTH  assembled parallel word.
REQ-009 SHALL have port out_valid  output  1  d_out holds a complete word.
REQ-010 SHALL have port out_ready  input  1  consumer takes d_out this cycle.
REQ-011 SHALL have port overrun  output  1  sticky flag: a bit was offered while s_ready was low.
REQ-012 SHALL have port parity_err  output  1  parity failure of held word (present only when DESER_PARITY_EN is defined).

Function
REQ-013 Bit accept SHALL occur on a rising edge where s_valid=1 and s_ready=1; no other condition shifts data.
REQ-014 FSM states SHALL be IDLE, COLLECT, PARITY (macro only), HOLD; a bit counter counts accepted data bits 0..WIDTH-1.
REQ-015 IDLE: s_ready=1, out_valid=0; accepted bit -> COLLECT, counter=1.
REQ-016 COLLECT: s_ready=1; each accepted bit increments the counter; the WIDTH-th data bit -> HOLD (or PARITY with macro), counter=0.
REQ-017 MSB_FIRST=1: internal shift register shifts left, new bit enters bit 0; MSB_FIRST=0: shifts right, new bit enters bit WIDTH-1.
REQ-018 d_out SHALL be a separate register loaded from the completed shift value; out_valid SHALL rise on the clock edge that accepts the last bit (one-cycle latency from last bit to visible word).
REQ-019 HOLD: out_valid=1, d_out stable; s_ready SHALL equal out_ready (combinational).
REQ-020 HOLD with out_valid=1 and out_ready=1: word consumed; if a bit is accepted the same cycle it is bit 1 of the next word -> COLLECT, counter=1; else -> IDLE, out_valid=0.
REQ-021 s_valid=1 while s_ready=0 SHALL drop the bit, leave state/data unchanged, and set overrun=1 on that edge; overrun clears only on reset.
REQ-022 d_out SHALL retain the last word after out_valid falls until the next word completes.
REQ-023 s_bit SHALL be ignored whenever s_valid=0; X on s_bit with s_valid=0 SHALL not propagate.

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, counter=0, shift register=0, d_out=0, out_valid=0, overrun=0, parity_err=0; s_ready=1 follows from IDLE.
REQ-025 Reset mid-word or in HOLD SHALL discard the partial or held word; the first bit accepted after release is bit 1 of a new word.

Configuration
REQ-026 Macro DESER_PARITY_EN defined: after WIDTH data bits, FSM enters PARITY (s_ready=1), accepts one even-parity bit, then loads d_out and enters HOLD; parity_err = XOR of data bits and parity bit, updated with d_out, cleared on reset.
REQ-027 Macro DESER_PARITY_EN undefined: no PARITY state, no parity_err port, word completes on WIDTH-th data bit.

Verification
REQ-028 WIDTH=4, MSB_FIRST=1, out_ready=1, bits 1,0,1,1 on consecutive cycles -> d_out=4'b1011, out_valid=1 one cycle after last bit, for one cycle.
REQ-029 MSB_FIRST=0, bits 1,0,1,1 -> d_out=4'b1101.
REQ-030 Word 1011 held with out_ready=0, s_valid=1 three cycles -> s_ready=0, d_out stays 1011, overrun=1; then out_ready=1 -> word consumed, overrun stays 1.
REQ-031 Back-to-back: out_ready=1, continuous s_valid, 8 bits 1,1,0,0,0,0,1,1 -> words 1100 then 0011, no dropped bit, overrun=0.
REQ-032 Reset asserted after bits 1,1 then released, bits 0,0,0,1 -> d_out=4'b0001, overrun=0.
REQ-033 DESER_PARITY_EN defined: bits 1,0,1,1 then parity 0 -> d_out=4'b1011, parity_err=1; parity 1 -> parity_err=0.
